interrupt_ctrl_4ch: RTL and testbench

INTERRUPT_CTRL_4CH -- requirements
Module: interrupt_ctrl_4ch

---
 rtl/irq_ctrl_pkg.sv | 12 +
 rtl/irq_priority_enc.sv | 21 ++
 rtl/interrupt_ctrl_4ch.sv | 80 ++++++++
 tb/tb_interrupt_ctrl_4ch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and state encoding for the 4-channel interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned NUM_IRQ  = 4;
  localparam int unsigned ID_WIDTH = 2;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational fixed-priority encoder; the highest set bit wins.
module irq_priority_enc
  import irq_ctrl_pkg::*;
(
  input  logic [NUM_IRQ-1:0]  req,
  output logic [ID_WIDTH-1:0] id,
  output logic                any
);

  always_comb begin
    id  = '0;
    any = |req;
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i]) begin
        id = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl_4ch.sv
// Four-channel interrupt controller: edge/level capture, pending register,
// two-state present/acknowledge FSM with registered outputs.
module interrupt_ctrl_4ch
  import irq_ctrl_pkg::*;
#(
  parameter logic EDGE_TRIG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  mask,
  input  logic                irq_ack,
  output logic                irq_valid,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic [NUM_IRQ-1:0]  pending
);

  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  rise, clr;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] enc_id;
  logic                enc_any;
  logic                valid_q;
  logic                accept;
  state_e              state_q, state_d;

  irq_priority_enc u_enc (
    .req (pending_q & mask),
    .id  (enc_id),
    .any (enc_any)
  );

  assign rise   = irq & ~irq_q;
  assign accept = (state_q == ACTIVE) && irq_ack;
  assign clr    = accept ? (NUM_IRQ'(1) << id_q) : '0;

  // A rise landing on the same edge as its own clear keeps the bit pending.
  assign pending_d = EDGE_TRIG ? ((pending_q & ~clr) | rise) : irq;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = ACTIVE;
          id_d    = enc_id;
        end
      end
      ACTIVE: begin
        if (irq_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      id_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      state_q   <= state_d;
      id_q      <= id_d;
      valid_q   <= (state_d == ACTIVE);
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_interrupt_ctrl_4ch.sv
// Scoreboard bench: edge- and level-mode instances checked every cycle
// against a per-channel behavioural model.
module tb_interrupt_ctrl_4ch;

  typedef struct packed {
    logic [3:0] p;
    logic       v;
    logic [1:0] id;
    logic       cid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq = '0;
  logic [3:0] mask = '0;
  logic       irq_ack = 1'b0;

  logic       valid_w [2];
  logic [1:0] id_w    [2];
  logic [3:0] pend_w  [2];

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;
  bit done = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  // Behavioural model state, one slot per instance (0 = edge, 1 = level).
  bit [3:0] m_pend [2];
  bit [3:0] m_prev [2];
  int       m_serve[2];
  bit [1:0] m_id   [2];

  always #5 clk = ~clk;

  interrupt_ctrl_4ch #(.EDGE_TRIG(1'b1)) u_edge (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (valid_w[0]),
    .irq_id    (id_w[0]),
    .pending   (pend_w[0])
  );

  interrupt_ctrl_4ch #(.EDGE_TRIG(1'b0)) u_lvl (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (valid_w[1]),
    .irq_id    (id_w[1]),
    .pending   (pend_w[1])
  );

  function automatic exp_t step(int inst, logic [3:0] irq_v, logic [3:0] mask_v,
                                logic ack_v, logic rst_v);
    exp_t     e;
    bit [3:0] np;
    int       best;
    e.cid = 1'b0;
    if (rst_v) begin
      m_pend[inst]  = '0;
      m_prev[inst]  = '0;
      m_serve[inst] = -1;
      m_id[inst]    = '0;
      e.cid         = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (inst == 1) np[i] = irq_v[i];
        else if (irq_v[i] && !m_prev[inst][i]) np[i] = 1'b1;
        else if (m_serve[inst] == i && ack_v) np[i] = 1'b0;
        else np[i] = m_pend[inst][i];
      end
      if (m_serve[inst] >= 0) begin
        if (ack_v) m_serve[inst] = -1;
      end else begin
        best = -1;
        for (int i = 3; i >= 0; i--) begin
          if (best < 0 && m_pend[inst][i] && mask_v[i]) best = i;
        end
        m_serve[inst] = best;
        if (best >= 0) m_id[inst] = 2'(best);
      end
      m_prev[inst] = irq_v;
      m_pend[inst] = np;
    end
    e.p  = m_pend[inst];
    e.v  = (m_serve[inst] >= 0);
    e.id = m_id[inst];
    if (e.v) e.cid = 1'b1;
    return e;
  endfunction

  task automatic cyc(logic [3:0] irq_v, logic [3:0] mask_v, logic ack_v, logic rst_v);
    @(negedge clk);
    irq     = irq_v;
    mask    = mask_v;
    irq_ack = ack_v;
    rst     = rst_v;
    q0.push_back(step(0, irq_v, mask_v, ack_v, rst_v));
    q1.push_back(step(1, irq_v, mask_v, ack_v, rst_v));
    started = 1'b1;
  endtask

  function automatic void check(string nm, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endfunction

  // Monitor: every edge after stimulus starts, pop and compare both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (q0.size() == 0 || q1.size() == 0) begin
        if (started) check("scoreboard_underflow", 1, 0);
      end else begin
        e = q0.pop_front();
        check("edge_pending", int'(pend_w[0]), int'(e.p));
        check("edge_valid", int'(valid_w[0]), int'(e.v));
        if (e.cid) check("edge_id", int'(id_w[0]), int'(e.id));
        e = q1.pop_front();
        check("lvl_pending", int'(pend_w[1]), int'(e.p));
        check("lvl_valid", int'(valid_w[1]), int'(e.v));
        if (e.cid) check("lvl_id", int'(id_w[1]), int'(e.id));
      end
    end
  end

  initial begin
    logic [3:0] ri, rm;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0; m_prev[k] = '0; m_serve[k] = -1; m_id[k] = '0;
    end
    cyc(4'h0, 4'hF, 1'b0, 1'b1);
    cyc(4'h0, 4'hF, 1'b0, 1'b1);
    repeat (3) cyc(4'h0, 4'hF, 1'b0, 1'b0);
    // Single pulse on channel 2.
    cyc(4'b0100, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    // Two channels at once: 3 then 1.
    cyc(4'b1010, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    repeat (3) cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    // Higher priority arrives mid-service; id must hold.
    cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b1000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    // Re-rise on the ack edge keeps channel 1 pending.
    cyc(4'b0010, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0010, 4'hF, 1'b1, 1'b0);
    cyc(4'b0010, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    // Masked channel waits, then becomes serviceable.
    cyc(4'b0100, 4'h0, 1'b0, 1'b0);
    cyc(4'b0000, 4'h0, 1'b0, 1'b0);
    cyc(4'b0000, 4'h0, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0100, 1'b1, 1'b0);
    // Reset during service; held line re-pends after reset.
    cyc(4'b1001, 4'hF, 1'b0, 1'b0);
    cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    cyc(4'b0001, 4'hF, 1'b0, 1'b1);
    cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    cyc(4'b0001, 4'hF, 1'b1, 1'b0);
    repeat (2) cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    // Randomised traffic.
    ri = '0;
    rm = 4'hF;
    for (int n = 0; n < 2000; n++) begin
      ri = ri ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) rm = 4'($urandom_range(0, 15));
      cyc(ri, rm, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
    @(posedge clk);
    #2;
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
